// File: rtl/regfile_arbiter.sv
// regfile_arbiter: 16 x DW register file (r0 hardwired to zero) shared by two
// requesters through a single round-robin arbitrated access slot per cycle.
module regfile_arbiter #(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqA,
  input  logic             weA,
  input  logic [3:0]       addrA,
  input  logic [DW-1:0]    wdataA,
  output logic             gntA,
  output logic             rvalidA,
  output logic [DW-1:0]    rdataA,
  input  logic             reqB,
  input  logic             weB,
  input  logic [3:0]       addrB,
  input  logic [DW-1:0]    wdataB,
  output logic             gntB,
  output logic             rvalidB,
  output logic [DW-1:0]    rdataB,
  output logic [16*DW-1:0] regOut,
  output logic             lastGnt
);

  // Registers 1..15 only; r0 has no storage.
  logic [DW-1:0] regs_q [1:15];
  logic [DW-1:0] regs_d [1:15];

  logic          gntA_q, gntA_d, gntB_q, gntB_d;
  logic          rvalidA_q, rvalidA_d, rvalidB_q, rvalidB_d;
  logic [DW-1:0] rdataA_q, rdataA_d, rdataB_q, rdataB_d;
  logic          lastGnt_q, lastGnt_d;

  logic          eligA, eligB, winA, winB;

  // Register lookup with r0 reading as zero.
  function automatic logic [DW-1:0] rd_reg(input logic [3:0] a);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 1; i < 16; i++) begin
      if (a == 4'(i)) v = regs_q[i];
    end
    return v;
  endfunction

  // Round-robin arbitration: a requester granted last cycle sits out this edge.
  always_comb begin
    eligA = reqA & ~gntA_q;
    eligB = reqB & ~gntB_q;
    winA  = eligA & (~eligB | lastGnt_q);
    winB  = eligB & (~eligA | ~lastGnt_q);
  end

  // Next-state for storage, read data, grant pulses and the round-robin pointer.
  always_comb begin
    regs_d    = regs_q;
    gntA_d    = winA;
    gntB_d    = winB;
    rvalidA_d = winA & ~weA;
    rvalidB_d = winB & ~weB;
    rdataA_d  = rdataA_q;
    rdataB_d  = rdataB_q;
    lastGnt_d = lastGnt_q;
    for (int i = 1; i < 16; i++) begin
      if (winA && weA && addrA == 4'(i)) regs_d[i] = wdataA;
      if (winB && weB && addrB == 4'(i)) regs_d[i] = wdataB;
    end
    // Reads sample the pre-edge contents; only one access wins per edge.
    if (winA && !weA) rdataA_d = rd_reg(addrA);
    if (winB && !weB) rdataB_d = rd_reg(addrB);
    if (winA)      lastGnt_d = 1'b0;
    else if (winB) lastGnt_d = 1'b1;
  end

  // State registers; reset leaves lastGnt at B so A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 16; i++) regs_q[i] <= '0;
      gntA_q    <= 1'b0;
      gntB_q    <= 1'b0;
      rvalidA_q <= 1'b0;
      rvalidB_q <= 1'b0;
      rdataA_q  <= '0;
      rdataB_q  <= '0;
      lastGnt_q <= 1'b1;
    end else begin
      regs_q    <= regs_d;
      gntA_q    <= gntA_d;
      gntB_q    <= gntB_d;
      rvalidA_q <= rvalidA_d;
      rvalidB_q <= rvalidB_d;
      rdataA_q  <= rdataA_d;
      rdataB_q  <= rdataB_d;
      lastGnt_q <= lastGnt_d;
    end
  end

  // Packed register view; slot 0 is constant zero.
  always_comb begin
    regOut = '0;
    for (int i = 1; i < 16; i++) regOut[i*DW +: DW] = regs_q[i];
  end

  assign gntA    = gntA_q;
  assign gntB    = gntB_q;
  assign rvalidA = rvalidA_q;
  assign rvalidB = rvalidB_q;
  assign rdataA  = rdataA_q;
  assign rdataB  = rdataB_q;
  assign lastGnt = lastGnt_q;

endmodule
